// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and types for the instruction fetch stage
//
// Holds the NOP encoding that fills the IF/ID register out of reset, the
// default reset PC and the fetch state machine encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with a one-entry hold buffer
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   flush            drop the live entry (redirect)
//   load             take in_inst/in_pc straight into IF/ID
//   capture          park in_inst/in_pc in the hold buffer (slot busy)
//   unhold           move the hold buffer into IF/ID
//   consume          decode takes the live entry this cycle
//   in_inst, in_pc   returned instruction word and its PC
//   id_valid, id_inst, id_pc   IF/ID register outputs
module if_id_reg
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        capture,
  input  logic        unhold,
  input  logic        consume,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  logic [31:0] hold_inst;
  logic [31:0] hold_pc;

  // The hold buffer has no valid bit of its own: the fetch FSM sitting in
  // HOLD is what marks it live, so leaving HOLD on a flush drops it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_valid  <= 1'b0;
      id_inst   <= NOP_INST;
      id_pc     <= 32'h0000_0000;
      hold_inst <= NOP_INST;
      hold_pc   <= 32'h0000_0000;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else begin
      if (load) begin
        id_valid <= 1'b1;
        id_inst  <= in_inst;
        id_pc    <= in_pc;
      end else if (unhold) begin
        id_valid <= 1'b1;
        id_inst  <= hold_inst;
        id_pc    <= hold_pc;
      end else if (consume) begin
        id_valid <= 1'b0;
      end
      if (capture) begin
        hold_inst <= in_inst;
        hold_pc   <= in_pc;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with IF/ID register
//
// One outstanding request at a time on a req/gnt/rvalid memory interface.
// Optional macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises the
// sticky misalign_err and halts fetching until reset; without it the low two
// redirect bits are ignored and misalign_err is tied low.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   imem_req, imem_addr              fetch request and address (= pc)
//   imem_gnt, imem_rvalid, imem_rdata  grant, response valid, instruction word
//   redirect_valid, redirect_pc      taken branch/jump pulse and target
//   stall                            decode does not consume id_* this cycle
//   id_valid, id_inst, id_pc, id_pc_plus4  IF/ID register outputs
//   misalign_err                     sticky misaligned-redirect flag
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        misalign_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  redir_target;
  logic         kill;
  logic         slot_free;
  logic         rsp_live;
  logic         load_new;
  logic         capture;
  logic         unhold;
  logic         consume;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign redir_target = redirect_pc;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_target        = {redirect_pc[31:2], 2'b00};
  assign misalign_err        = 1'b0;
`endif

  // Held low during reset so the first request appears only once reset is
  // released; also held low forever after a misaligned redirect.
  assign imem_req  = !reset && (state == FETCH) && !kill && !misalign_err;
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  assign slot_free = !id_valid || !stall;
  // A response that arrives while kill is set belongs to the old path.
  assign rsp_live  = (state == WAIT) && imem_rvalid && !kill;
  assign load_new  = rsp_live && slot_free && !redirect_valid;
  assign capture   = rsp_live && !slot_free && !redirect_valid;
  assign unhold    = (state == HOLD) && !stall && !redirect_valid;
  assign consume   = id_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
      kill  <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redir_target;
      // A request already accepted (granted now, or waiting without its
      // response yet) will still return a word, which must be discarded.
      if ((imem_req && imem_gnt) || ((state == WAIT) && !imem_rvalid)) begin
        state <= WAIT;
        kill  <= 1'b1;
      end else begin
        state <= FETCH;
        kill  <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= FETCH;
            end else if (slot_free) begin
              pc    <= pc_plus4;
              state <= FETCH;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .load     (load_new),
    .capture  (capture),
    .unhold   (unhold),
    .consume  (consume),
    .in_inst  (imem_rdata),
    .in_pc    (pc),
    .id_valid (id_valid),
    .id_inst  (id_inst),
    .id_pc    (id_pc)
  );

  assign id_pc_plus4 = id_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .misalign_err   (misalign_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_consumed = 0;

  // memory responder state
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 0;
  bit          dead_next = 0;
  bit          gnt_en = 1;
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;

  // reference model: expected stream of consumed PCs
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  bit          rand_en = 0;
  bit          pend_redir = 0;
  logic [31:0] pend_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0080_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  function automatic void refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: memory responder plus stall/redirect stimulus, driven at negedge.
  task automatic step(input bit stl, input bit rdv, input logic [31:0] rdpc);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = dead_next ? 32'hDEAD_BEEF : mem_word(pend_addr);
        dead_next   = 0;
        pend        = 0;
      end else begin
        pend_cnt--;
      end
    end
    if (imem_req && !pend && gnt_en && ($urandom_range(99, 0) < gnt_pct)) begin
      imem_gnt  = 1'b1;
      pend      = 1;
      pend_cnt  = $urandom_range(lat_max, lat_min) - 1;
      pend_addr = imem_addr;
    end
    stall          = stl;
    redirect_valid = rdv;
    redirect_pc    = rdpc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; redirect_valid = 0; stall = 0;
    pend = 0; dead_next = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops expected PCs as decode consumes entries, plus protocol checks.
  initial begin
    bit          have_prev = 0;
    bit          p_hold = 0, p_req = 0, p_gnt = 0, p_redir = 0;
    logic [31:0] p_pc = 0, p_inst = 0, p_addr = 0, e;
    forever begin
      @(negedge clk);
      #2;
      if (rand_en) begin
        if (have_prev) begin
          if (p_hold) begin
            chk("stall_hold_valid", id_valid, 1);
            chk("stall_hold_pc", id_pc, p_pc);
            chk("stall_hold_inst", id_inst, p_inst);
          end
          if (p_req && !p_gnt && !p_redir) begin
            chk("req_stable", imem_req, 1);
            chk("addr_stable", imem_addr, p_addr);
          end
        end
        if (imem_req) chk("one_outstanding", pend && !imem_gnt, 0);
        if (id_valid && !stall) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sb_pc", id_pc, e);
            chk("sb_inst", id_inst, mem_word(e));
            chk("sb_pc_plus4", id_pc_plus4, e + 32'd4);
            n_consumed++;
            refill();
          end
        end
        p_hold  = id_valid && stall && !redirect_valid;
        p_req   = imem_req;
        p_gnt   = imem_gnt;
        p_redir = redirect_valid;
        p_pc    = id_pc;
        p_inst  = id_inst;
        p_addr  = imem_addr;
        have_prev = 1;
      end else begin
        have_prev = 0;
      end
    end
  end

  initial begin
    bit          stl, rd;
    logic [31:0] tgt;
    reset = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; stall = 0;
    #7;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_inst", id_inst, NOP_INST);
    chk("rst_pc", id_pc, 0);
    chk("rst_pc_plus4", id_pc_plus4, 4);
    chk("rst_misalign", misalign_err, 0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RESET_PC_DEFAULT);

    // zero-latency memory: id_valid every second cycle, PCs 0,4,8
    for (int k = 1; k <= 8; k++) begin
      bit ev;
      step(0, 0, 0);
      ev = (k >= 3) && (k % 2 == 1);
      chk("zl_valid", id_valid, ev);
      if (ev) begin
        chk("zl_pc", id_pc, 4 * ((k - 3) / 2));
        chk("zl_inst", id_inst, mem_word(4 * ((k - 3) / 2)));
      end
    end

    // stall for 5 cycles while a response arrives
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 0);
      chk("stall_valid", id_valid, 1);
      chk("stall_pc", id_pc, 32'hC);
      chk("stall_inst", id_inst, 32'h0080_0093);
      if (k >= 2) chk("hold_no_req", imem_req, 0);
    end
    step(0, 0, 0);
    chk("release_old_pc", id_pc, 32'hC);
    lat_min = 2; lat_max = 2;
    step(0, 0, 0);
    chk("release_valid", id_valid, 1);
    chk("release_pc", id_pc, 32'h10);
    chk("release_inst", id_inst, mem_word(32'h10));
    chk("release_pc_plus4", id_pc_plus4, 32'h14);

    // redirect while waiting; stale response carries DEADBEEF
    dead_next = 1;
    step(0, 1, 32'h100);
    step(0, 0, 0);
    chk("kill_valid", id_valid, 0);
    chk("kill_no_req", imem_req, 0);
    step(0, 0, 0);
    chk("kill_valid2", id_valid, 0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 32'h100);
    lat_min = 1; lat_max = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("post_kill_valid", id_valid, 1);
    chk("post_kill_pc", id_pc, 32'h100);
    chk("post_kill_inst", id_inst, mem_word(32'h100));

    // redirect in the same cycle as the response
    step(0, 1, 32'h200);
    lat_min = 2; lat_max = 2;
    step(0, 0, 0);
    chk("same_cyc_valid", id_valid, 0);
    chk("same_cyc_req", imem_req, 1);
    chk("same_cyc_addr", imem_addr, 32'h200);

    // reset asserted mid-WAIT
    step(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_valid", id_valid, 0);
    chk("mid_rst_inst", id_inst, NOP_INST);
    chk("mid_rst_pc", id_pc, 0);
    pend = 0;
    @(negedge clk);
    reset = 1'b0;
    imem_gnt = 0; imem_rvalid = 0;
    #1;
    chk("after_rst_req", imem_req, 1);
    chk("after_rst_addr", imem_addr, RESET_PC_DEFAULT);

    // misaligned redirect
    lat_min = 1; lat_max = 1;
    gnt_en = 0;
    step(0, 1, 32'h102);
    step(0, 0, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", misalign_err, 1);
    chk("mis_req", imem_req, 0);
    gnt_en = 1;
    repeat (3) step(0, 0, 0);
    chk("mis_req_stuck", imem_req, 0);
    chk("mis_valid", id_valid, 0);
    chk("mis_err_sticky", misalign_err, 1);
`else
    chk("mis_err_tied", misalign_err, 0);
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, 32'h100);
`endif
    gnt_en = 1;

    // randomized phase against the stream model
    do_reset();
    lat_min = 1; lat_max = 3; gnt_pct = 75;
    gen_pc = RESET_PC_DEFAULT;
    exp_q.delete();
    refill();
    rand_en = 1;
    for (int i = 0; i < 3000; i++) begin
      stl = ($urandom_range(2, 0) == 0);
      rd  = ($urandom_range(24, 0) == 0);
      if ($urandom_range(7, 0) == 0) tgt = 32'hFFFF_FFF0 + ($urandom_range(3, 0) << 2);
      else tgt = $urandom_range(255, 0) << 2;
`ifndef FETCH_MISALIGN_CHECK_EN
      tgt = tgt | $urandom_range(3, 0);
`endif
      step(stl, rd, tgt);
      if (pend_redir) begin
        exp_q.delete();
        gen_pc = pend_tgt;
        refill();
        pend_redir = 0;
      end
      if (rd) begin
        pend_redir = 1;
        pend_tgt   = {tgt[31:2], 2'b00};
      end
    end
    rand_en = 0;
    step(0, 0, 0);
    chk("progress", (n_consumed > 150) ? 32'd1 : 32'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage with IF/ID pipeline register. Keeps the PC and issues one outstanding request at a time on the instruction-memory request/grant/response interface. Registers each returned word with its PC into the IF/ID register, which drives `inst_code` into the immediate generator and decoder. Supports decode back-pressure (`stall`) and control-flow redirects from execute, and discards a response that is in flight when a redirect arrives.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; equals the PC.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  new PC.
- `stall`  in  1  decode does not consume `id_*` this cycle.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_inst`  out  32  instruction; feeds `inst_code` of the immediate generator.
- `id_pc`  out  32  PC of `id_inst`.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.
- `misalign_err`  out  1  sticky misaligned-redirect flag.

## Operation
- The state machine has three states: FETCH, WAIT and HOLD. It resets to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=pc. On `imem_gnt` the block moves to WAIT. Without a grant, the request and address stay stable.
- WAIT: `imem_req`=0. On `imem_rvalid` the slot decides the next step:
  - The slot is free when `!id_valid || !stall`.
  - Slot free: load `id_inst`, `id_pc` and `id_valid`=1, set pc <= pc+4, then go to FETCH.
  - Slot busy: capture the word and its PC into the hold buffer, then go to HOLD.
- HOLD: while `stall`=1 the block waits. When `stall`=0, the hold buffer moves into IF/ID, pc <= pc+4, and the block goes to FETCH.
- When decode consumes an entry (`id_valid && !stall`) and no new word is loaded that cycle, `id_valid` drops to 0.
- PC arithmetic is 32-bit. 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect has priority over everything except reset, and it acts on the next edge:
  - pc <= `redirect_pc`; `id_valid` <= 0; the hold buffer is dropped.
  - Redirect in FETCH without a grant: go to FETCH at the new address.
  - Redirect in FETCH with a same-cycle grant, or redirect in WAIT: set `kill`.
  - While `kill` is set, the next `imem_rvalid` is discarded and clears `kill`. The next request waits until then.
  - Redirect during the same cycle as a slot-free rvalid: the word is discarded.
- Reset applies asynchronously. It overrides any in-flight transaction, and the responder is required to drop its response.
- Reset values:
  - pc = `RESET_PC`; `imem_req`=0 while reset is asserted.
  - `id_valid`=0, `id_inst`=32'h0000_0013 (NOP), `id_pc`=0, `id_pc_plus4`=4.
  - `misalign_err`=0, `kill`=0.

## Timing
- A response at edge n appears on `id_*` after edge n.
- Best-case throughput is 1 instruction every 2 cycles: request, grant, then response the next cycle.
- The first `imem_req` is asserted in the first cycle after reset deasserts.
- A redirect at cycle n gives `imem_addr`=`redirect_pc` in cycle n+1, or after the killed response if one is in flight.
- `id_*` holds stable for every cycle in which `stall`=1 and `id_valid`=1.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined: a redirect with `redirect_pc[1:0]`≠0 does the following:
  - sets `misalign_err`=1;
  - clears `id_valid`;
  - stops fetching, with `imem_req` held at 0 until reset.
- Undefined: `redirect_pc[1:0]` is forced to 2'b00 and `misalign_err` is tied to 0.

## Structure
- Package `riscv_pkg` holds:
  - `NOP_INST` = 32'h0000_0013;
  - `fetch_state_t` enum {FETCH, WAIT, HOLD};
  - the `RESET_PC` default constant.
- Sub-module `if_id_reg`: the IF/ID register and the one-entry hold buffer, with load, stall and flush controls. `instr_fetch` instantiates it once.

## Test plan
- Zero-latency memory (grant in FETCH, rvalid the next cycle) from reset → `id_pc` = 0, 4, 8 with `id_valid` pulsing every 2 cycles; the words match memory.
- `stall`=1 for 5 cycles while `id_inst`=32'h0080_0093, with a response arriving → `id_*` unchanged, state HOLD; after release the next word appears with `id_pc` incremented by 4.
- Redirect to 32'h0000_0100 in WAIT; the stale rvalid carries 32'hDEAD_BEEF → no `id_valid`; the next `imem_addr`=32'h100.
- Redirect and rvalid in the same cycle → the word is dropped and `id_valid`=0.
- Reset asserted mid-WAIT → `imem_req`=0, `id_inst`=NOP and `id_valid`=0 immediately; after release `imem_addr`=`RESET_PC`.
- With `FETCH_MISALIGN_CHECK_EN`, redirect to 32'h0000_0102 → `misalign_err`=1 and `imem_req` stays 0. Without the macro → `imem_addr`=32'h0000_0100.
